// File: rtl/clkdiv_ctrl.sv
// Glitch-free programmable clock divider with a req/ack ratio-change handshake.
// Ratio changes and disables land only on phase boundaries; low phases may be cut short.
module clkdiv_ctrl #(
  parameter int          CW      = 8,
  parameter int unsigned DIV_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          req,
  input  logic [CW-1:0] div_in,
  output logic          ack,
  output logic          busy,
  output logic [CW-1:0] cur_div,
  output logic          clk_out,
  output logic          tick
);

  typedef enum logic [1:0] {S_OFF = 2'd0, S_RUN = 2'd1, S_PEND = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cur_div_q, cur_div_d;
  logic [CW-1:0] pend_div_q, pend_div_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          stop_q, stop_d;

  logic active, at_end, fall, low_off, stop_now;

  assign active   = (state_q != S_OFF);
  assign at_end   = (cnt_q == cur_div_q);
  assign fall     = active && clk_out_q && at_end;
  assign low_off  = active && !clk_out_q && !en;
  // A disable seen anywhere in a high phase is remembered until the falling boundary.
  assign stop_now = stop_q || !en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      cur_div_q  <= CW'(DIV_RST);
      pend_div_q <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (low_off || (fall && stop_now)) state_d = S_OFF;
        else if (req)                      state_d = S_PEND;
      end
      S_PEND: begin
        if (low_off || (fall && stop_now)) state_d = S_OFF;
        else if (fall)                     state_d = S_RUN;
      end
      default: begin
        if (en) state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    stop_d     = stop_q;
    if (!active) begin
      cnt_d     = '0;
      clk_out_d = en;
      tick_d    = en;
      if (req) begin
        cur_div_d = div_in;
        ack_d     = 1'b1;
      end
    end else begin
      if (low_off) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end else if (at_end) begin
        cnt_d     = '0;
        clk_out_d = !clk_out_q;
        tick_d    = !clk_out_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (clk_out_q && !en) stop_d = 1'b1;
      if (state_q == S_PEND && state_d != S_PEND) begin
        cur_div_d = pend_div_q;
        ack_d     = 1'b1;
      end
      // A request in RUN that coincides with shutting down is applied at once.
      if (state_q == S_RUN && req && state_d == S_OFF) begin
        cur_div_d = div_in;
        ack_d     = 1'b1;
      end
      if (state_q == S_RUN && state_d == S_PEND) pend_div_d = div_in;
    end
    if (state_d == S_OFF) stop_d = 1'b0;
  end

  assign busy_d  = (state_d == S_PEND);

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign cur_div = cur_div_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: directed vector table, async-reset sequence and
// randomized traffic checked against a phase-countdown reference model.
module tb_clkdiv_ctrl;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          req;
  logic [CW-1:0] div_in;
  logic          ack, busy, clk_out, tick;
  logic [CW-1:0] cur_div;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clkdiv_ctrl #(.CW(CW), .DIV_RST(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .div_in(div_in),
    .ack(ack), .busy(busy), .cur_div(cur_div), .clk_out(clk_out), .tick(tick)
  );

  typedef struct {
    bit       en;
    bit       req;
    int       div;
    bit       x_clk;
    bit       x_tick;
    bit       x_ack;
    bit       x_busy;
    int       x_div;
  } vec_t;

  vec_t vecs[$];

  // Reference model: on/off, phase level and cycles left in the current phase.
  bit m_on, m_hi, m_pend, m_stop, m_tick, m_ack;
  int m_left, m_div, m_pdiv;

  function automatic void model_reset();
    m_on = 0; m_hi = 0; m_pend = 0; m_stop = 0; m_tick = 0; m_ack = 0;
    m_left = 0; m_div = 1; m_pdiv = 0;
  endfunction

  function automatic void model_step(input bit e, input bit r, input int d);
    bit had;
    m_ack = 0; m_tick = 0;
    had = m_pend;
    if (!m_on) begin
      if (r) begin m_div = d; m_ack = 1; end
      if (e) begin m_on = 1; m_hi = 1; m_left = m_div + 1; m_tick = 1; end
    end else if (!m_hi && !e) begin
      m_on = 0;
      if (had) begin m_div = m_pdiv; m_pend = 0; m_ack = 1; end
      else if (r) begin m_div = d; m_ack = 1; end
    end else begin
      if (m_hi && !e) m_stop = 1;
      m_left--;
      if (m_left == 0 && m_hi) begin
        m_hi = 0;
        if (had) begin m_div = m_pdiv; m_pend = 0; m_ack = 1; end
        if (m_stop) begin
          m_on = 0; m_stop = 0;
          if (!had && r) begin m_div = d; m_ack = 1; end
        end else if (!had && r) begin
          m_pend = 1; m_pdiv = d;
        end
        m_left = m_div + 1;
      end else begin
        if (m_left == 0) begin m_hi = 1; m_tick = 1; m_left = m_div + 1; end
        if (!had && r) begin m_pend = 1; m_pdiv = d; end
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit e, input bit r, input int d);
    en = e; req = r; div_in = CW'(d);
    @(posedge clk);
    #1;
    model_step(e, r, d);
    req = 1'b0;
  endtask

  task automatic check_model();
    check("clk_out", int'(clk_out), int'(m_on && m_hi));
    check("tick",    int'(tick),    int'(m_tick));
    check("ack",     int'(ack),     int'(m_ack));
    check("busy",    int'(busy),    int'(m_pend));
    check("cur_div", int'(cur_div), m_div);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; req = 1'b0; div_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic add(input bit e, input bit r, input int d,
                     input bit c, input bit t, input bit a, input bit b, input int cd);
    vec_t v;
    v.en = e; v.req = r; v.div = d;
    v.x_clk = c; v.x_tick = t; v.x_ack = a; v.x_busy = b; v.x_div = cd;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset defaults, ratio change 1->3, busy rejection, disable mid-high, clk/2 start.
    add(1,0,0, 1,1,0,0,1); add(1,0,0, 1,0,0,0,1); add(1,0,0, 0,0,0,0,1);
    add(1,0,0, 0,0,0,0,1); add(1,0,0, 1,1,0,0,1); add(1,1,3, 1,0,0,1,1);
    add(1,0,0, 0,0,1,0,3); add(1,0,0, 0,0,0,0,3); add(1,0,0, 0,0,0,0,3);
    add(1,0,0, 0,0,0,0,3); add(1,0,0, 1,1,0,0,3); add(1,1,2, 1,0,0,1,3);
    add(1,1,5, 1,0,0,1,3); add(1,0,0, 1,0,0,1,3); add(1,0,0, 0,0,1,0,2);
    add(1,0,0, 0,0,0,0,2); add(1,0,0, 0,0,0,0,2); add(1,0,0, 1,1,0,0,2);
    add(0,0,0, 1,0,0,0,2); add(0,0,0, 1,0,0,0,2); add(0,0,0, 0,0,0,0,2);
    add(0,0,0, 0,0,0,0,2); add(0,0,0, 0,0,0,0,2); add(1,1,0, 1,1,1,0,0);
    add(1,0,0, 0,0,0,0,0); add(1,0,0, 1,1,0,0,0); add(1,0,0, 0,0,0,0,0);
    add(0,0,0, 0,0,0,0,0);

    rst = 1'b0; en = 1'b0; req = 1'b0; div_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick",    int'(tick),    0);
    check("rst_ack",     int'(ack),     0);
    check("rst_busy",    int'(busy),    0);
    check("rst_cur_div", int'(cur_div), 1);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].req, vecs[i].div);
      check($sformatf("vec%0d_clk_out", i), int'(clk_out), int'(vecs[i].x_clk));
      check($sformatf("vec%0d_tick", i),    int'(tick),    int'(vecs[i].x_tick));
      check($sformatf("vec%0d_ack", i),     int'(ack),     int'(vecs[i].x_ack));
      check($sformatf("vec%0d_busy", i),    int'(busy),    int'(vecs[i].x_busy));
      check($sformatf("vec%0d_cur_div", i), int'(cur_div), vecs[i].x_div);
    end

    // Async reset while PEND with clk_out high.
    do_reset();
    drive(1, 0, 0);
    drive(1, 1, 4);
    check("pre_arst_busy", int'(busy), 1);
    check("pre_arst_clk",  int'(clk_out), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_clk_out", int'(clk_out), 0);
    check("arst_busy",    int'(busy),    0);
    check("arst_ack",     int'(ack),     0);
    check("arst_cur_div", int'(cur_div), 1);
    #3;
    rst = 1'b1;
    model_reset();
    begin
      int acks;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
        drive(0, 0, 0);
        if (ack) acks++;
      end
      check("post_arst_ack_count", acks, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit e, r;
      int d;
      e = ($urandom_range(0, 15) != 0);
      r = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
      drive(e, r, d);
      check_model();
      if (ack && busy) check("ack_busy_exclusive", 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
